frame_buffer_arbiter: RTL and testbench

Parametrised N-buffer frame arbiter between the camera capture writer and the display reader, generalising the fixed 3-buffer controller. Separate write and read grant channels carry distinct buffer IDs. The reader always receives the newest completed frame, and the writer never stalls while NUM_BUFFERS ≥ 3. Drop and repeat statistics are exported for debug.

---
 rtl/frame_buffer_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// N-buffer frame arbiter between a capture writer and a display reader.
// The reader always gets the newest completed frame; the writer never stalls.
module frame_buffer_arbiter #(
  parameter int NUM_BUFFERS = 3,
  parameter int CNT_W       = 16,
  localparam int ID_W       = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_req,
  input  logic             wr_done,
  input  logic             wr_abort,
  output logic             wr_grant,
  output logic [ID_W-1:0]  wr_id,
  input  logic             rd_req,
  input  logic             rd_done,
  output logic             rd_grant,
  output logic [ID_W-1:0]  rd_id,
  output logic             rd_new,
  output logic             frame_avail,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated
);

  if (NUM_BUFFERS < 3 || NUM_BUFFERS > 8) begin : g_bad_num_buffers
    $error("frame_buffer_arbiter: NUM_BUFFERS must be in 3..8");
  end

  typedef enum logic [2:0] {B_FREE, B_WRITING, B_READY, B_SHOWN, B_READING} buf_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEARCH, W_BUSY} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_SEARCH, R_BUSY} r_state_e;

  buf_state_e       buf_q [NUM_BUFFERS];
  buf_state_e       buf_d [NUM_BUFFERS];
  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]  latest_ptr_q, latest_ptr_d;
  logic             latest_valid_q, latest_valid_d;
  logic             wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d, rd_new_q, rd_new_d;
  logic [ID_W-1:0]  wr_id_q, wr_id_d, rd_id_q, rd_id_d;
  logic [CNT_W-1:0] dropped_q, dropped_d, repeated_q, repeated_d;

  logic             free_ok, shown_ok, ready_ok, sel_found, sel_drop, latest_ready;
  logic [ID_W-1:0]  free_idx, shown_idx, ready_idx, sel_idx;
  buf_state_e       cand_st;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Writer candidate search: latest frame is masked out by treating it as busy
  always_comb begin
    free_ok = 1'b0; shown_ok = 1'b0; ready_ok = 1'b0;
    free_idx = '0; shown_idx = '0; ready_idx = '0;
    latest_ready = 1'b0;
    cand_st = B_WRITING;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      cand_st = (latest_valid_q && latest_ptr_q == ID_W'(i)) ? B_WRITING : buf_q[i];
      latest_ready = latest_ready | ((latest_ptr_q == ID_W'(i)) && (buf_q[i] == B_READY));
      case (cand_st)
        B_FREE:  begin free_ok  = 1'b1; free_idx  = ID_W'(i); end
        B_SHOWN: begin shown_ok = 1'b1; shown_idx = ID_W'(i); end
        B_READY: begin ready_ok = 1'b1; ready_idx = ID_W'(i); end
        default: ;
      endcase
    end
    if (free_ok) begin
      sel_found = 1'b1; sel_idx = free_idx;  sel_drop = 1'b0;
    end else if (shown_ok) begin
      sel_found = 1'b1; sel_idx = shown_idx; sel_drop = 1'b0;
    end else if (ready_ok) begin
      sel_found = 1'b1; sel_idx = ready_idx; sel_drop = 1'b1;
    end else begin
      sel_found = 1'b0; sel_idx = '0;        sel_drop = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUFFERS; i++) buf_q[i] <= B_FREE;
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      latest_ptr_q   <= '0;
      latest_valid_q <= 1'b0;
      wr_grant_q     <= 1'b0;
      wr_id_q        <= '0;
      rd_grant_q     <= 1'b0;
      rd_id_q        <= '0;
      rd_new_q       <= 1'b0;
      dropped_q      <= '0;
      repeated_q     <= '0;
    end else begin
      buf_q          <= buf_d;
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      latest_ptr_q   <= latest_ptr_d;
      latest_valid_q <= latest_valid_d;
      wr_grant_q     <= wr_grant_d;
      wr_id_q        <= wr_id_d;
      rd_grant_q     <= rd_grant_d;
      rd_id_q        <= rd_id_d;
      rd_new_q       <= rd_new_d;
      dropped_q      <= dropped_d;
      repeated_q     <= repeated_d;
    end
  end

  // Next-state logic for both FSMs
  always_comb begin
    case (w_state_q)
      W_IDLE:   w_state_d = wr_req ? W_SEARCH : W_IDLE;
      W_SEARCH: w_state_d = sel_found ? W_BUSY : W_SEARCH;
      W_BUSY:   w_state_d = (wr_abort || wr_done) ? W_IDLE : W_BUSY;
      default:  w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:   r_state_d = rd_req ? R_SEARCH : R_IDLE;
      R_SEARCH: r_state_d = latest_valid_q ? R_BUSY : R_SEARCH;
      R_BUSY:   r_state_d = rd_done ? R_IDLE : R_BUSY;
      default:  r_state_d = R_IDLE;
    endcase
  end

  // Buffer ownership, grants and statistics; writer and reader never touch the same entry
  always_comb begin
    buf_d          = buf_q;
    latest_ptr_d   = latest_ptr_q;
    latest_valid_d = latest_valid_q;
    wr_grant_d     = 1'b0;
    wr_id_d        = wr_id_q;
    rd_grant_d     = 1'b0;
    rd_id_d        = rd_id_q;
    rd_new_d       = 1'b0;
    dropped_d      = dropped_q;
    repeated_d     = repeated_q;
    case (w_state_q)
      W_SEARCH: begin
        wr_grant_d = sel_found;
        wr_id_d    = sel_found ? sel_idx : wr_id_q;
        dropped_d  = (sel_found && sel_drop) ? sat_inc(dropped_q) : dropped_q;
        for (int i = 0; i < NUM_BUFFERS; i++)
          buf_d[i] = (sel_found && sel_idx == ID_W'(i)) ? B_WRITING : buf_d[i];
      end
      W_BUSY: begin
        if (wr_abort) begin
          for (int i = 0; i < NUM_BUFFERS; i++)
            buf_d[i] = (wr_id_q == ID_W'(i)) ? B_FREE : buf_d[i];
        end else if (wr_done) begin
          latest_ptr_d   = wr_id_q;
          latest_valid_d = 1'b1;
          for (int i = 0; i < NUM_BUFFERS; i++)
            buf_d[i] = (wr_id_q == ID_W'(i)) ? B_READY : buf_d[i];
        end else begin
          latest_valid_d = latest_valid_q;
        end
      end
      default: ;
    endcase
    case (r_state_q)
      R_SEARCH: begin
        rd_grant_d = latest_valid_q;
        rd_id_d    = latest_valid_q ? latest_ptr_q : rd_id_q;
        rd_new_d   = latest_valid_q && latest_ready;
        repeated_d = (latest_valid_q && !latest_ready) ? sat_inc(repeated_q) : repeated_q;
        for (int i = 0; i < NUM_BUFFERS; i++)
          buf_d[i] = (latest_valid_q && latest_ptr_q == ID_W'(i)) ? B_READING : buf_d[i];
      end
      R_BUSY: begin
        for (int i = 0; i < NUM_BUFFERS; i++)
          buf_d[i] = (rd_done && rd_id_q == ID_W'(i)) ? B_SHOWN : buf_d[i];
      end
      default: ;
    endcase
  end

  assign wr_grant        = wr_grant_q;
  assign wr_id           = wr_id_q;
  assign rd_grant        = rd_grant_q;
  assign rd_id           = rd_id_q;
  assign rd_new          = rd_new_q;
  assign frame_avail     = latest_valid_q;
  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed vector table on a 3-buffer arbiter plus saturation, soak and
// mid-frame reset sequences on a 5-buffer arbiter with 4-bit counters.
module tb_frame_buffer_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3_n, wq3, wd3, wa3, rq3, rdn3, wg3, rg3, rn3, fa3;
  logic [1:0]  wid3, rid3;
  logic [15:0] drop3, rep3;

  logic        rst5_n, wq5, wd5, wa5, rq5, rdn5, wg5, rg5, rn5, fa5;
  logic [2:0]  wid5, rid5;
  logic [3:0]  drop5, rep5;

  frame_buffer_arbiter #(.NUM_BUFFERS(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(rst3_n), .wr_req(wq3), .wr_done(wd3), .wr_abort(wa3),
    .wr_grant(wg3), .wr_id(wid3), .rd_req(rq3), .rd_done(rdn3), .rd_grant(rg3),
    .rd_id(rid3), .rd_new(rn3), .frame_avail(fa3), .frames_dropped(drop3),
    .frames_repeated(rep3));

  frame_buffer_arbiter #(.NUM_BUFFERS(5), .CNT_W(4)) dut5 (
    .clk(clk), .reset_n(rst5_n), .wr_req(wq5), .wr_done(wd5), .wr_abort(wa5),
    .wr_grant(wg5), .wr_id(wid5), .rd_req(rq5), .rd_done(rdn5), .rd_grant(rg5),
    .rd_id(rid5), .rd_new(rn5), .frame_avail(fa5), .frames_dropped(drop5),
    .frames_repeated(rep5));

  typedef struct {
    logic [4:0]  in;   // {wr_req, wr_done, wr_abort, rd_req, rd_done}
    logic [63:0] exp;  // {wg, wid, rg, rid, rn, fa, dropped, repeated}
  } vec_t;

  vec_t vecs [32];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int in, input int wg, input int wid, input int rg,
                              input int rid, input int rn, input int fa,
                              input int drop, input int rep);
    vec_t v;
    v.in  = 5'(in);
    v.exp = 64'({1'(wg), 2'(wid), 1'(rg), 2'(rid), 1'(rn), 1'(fa), 16'(drop), 16'(rep)});
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic w5(input bit ab);
    wq5 = 1'b1;
    tick;
    tick;
    chk("w5_grant_latency", 64'(wg5), 64'd1);
    wq5 = 1'b0;
    wa5 = ab;
    wd5 = ~ab;
    tick;
    wa5 = 1'b0;
    wd5 = 1'b0;
  endtask

  task automatic r5_get(output logic new_o);
    int n;
    n = 0;
    rq5 = 1'b1;
    do begin
      tick;
      n++;
    end while (!rg5 && n < 50);
    chk("r5_grant", 64'(rg5), 64'd1);
    new_o = rn5;
    rq5 = 1'b0;
  endtask

  task automatic r5_done;
    rdn5 = 1'b1;
    tick;
    rdn5 = 1'b0;
  endtask

  logic last_rn;
  bit   w_pend, w_own, r_pend, r_own, exp_wg, rpb;
  int   w_age, r_age;

  initial begin
    // Inputs {wq,wd,wa,rq,rdn}; outputs wg,wid,rg,rid,rn,fa,drop,rep after the edge
    vecs[0]  = mk('b10000, 0,0, 0,0,0, 0, 0,0);
    vecs[1]  = mk('b10000, 1,0, 0,0,0, 0, 0,0);
    vecs[2]  = mk('b01000, 0,0, 0,0,0, 1, 0,0);
    vecs[3]  = mk('b00010, 0,0, 0,0,0, 1, 0,0);
    vecs[4]  = mk('b00010, 0,0, 1,0,1, 1, 0,0);
    vecs[5]  = mk('b00001, 0,0, 0,0,0, 1, 0,0);
    vecs[6]  = mk('b00010, 0,0, 0,0,0, 1, 0,0);
    vecs[7]  = mk('b00010, 0,0, 1,0,0, 1, 0,1);
    vecs[8]  = mk('b10000, 0,0, 0,0,0, 1, 0,1);
    vecs[9]  = mk('b10000, 1,1, 0,0,0, 1, 0,1);
    vecs[10] = mk('b01000, 0,1, 0,0,0, 1, 0,1);
    vecs[11] = mk('b10000, 0,1, 0,0,0, 1, 0,1);
    vecs[12] = mk('b10000, 1,2, 0,0,0, 1, 0,1);
    vecs[13] = mk('b01000, 0,2, 0,0,0, 1, 0,1);
    vecs[14] = mk('b10000, 0,2, 0,0,0, 1, 0,1);
    vecs[15] = mk('b10000, 1,1, 0,0,0, 1, 1,1);
    vecs[16] = mk('b00100, 0,1, 0,0,0, 1, 1,1);
    vecs[17] = mk('b10000, 0,1, 0,0,0, 1, 1,1);
    vecs[18] = mk('b10000, 1,1, 0,0,0, 1, 1,1);
    vecs[19] = mk('b01000, 0,1, 0,0,0, 1, 1,1);
    vecs[20] = mk('b00001, 0,1, 0,0,0, 1, 1,1);
    vecs[21] = mk('b10000, 0,1, 0,0,0, 1, 1,1);
    vecs[22] = mk('b10000, 1,0, 0,0,0, 1, 1,1);
    vecs[23] = mk('b00010, 0,0, 0,0,0, 1, 1,1);
    vecs[24] = mk('b01010, 0,0, 1,1,1, 1, 1,1);
    vecs[25] = mk('b00001, 0,0, 0,1,0, 1, 1,1);
    vecs[26] = mk('b00010, 0,0, 0,1,0, 1, 1,1);
    vecs[27] = mk('b00010, 0,0, 1,0,1, 1, 1,1);
    vecs[28] = mk('b00001, 0,0, 0,0,0, 1, 1,1);
    vecs[29] = mk('b01101, 0,0, 0,0,0, 1, 1,1);
    vecs[30] = mk('b10000, 0,0, 0,0,0, 1, 1,1);
    vecs[31] = mk('b10000, 1,1, 0,0,0, 1, 1,1);

    {wq3, wd3, wa3, rq3, rdn3} = 5'b00000;
    {wq5, wd5, wa5, rq5, rdn5} = 5'b00000;
    rst3_n = 1'b0;
    rst5_n = 1'b0;
    repeat (3) tick;
    chk("reset3", 64'({wg3, wid3, rg3, rid3, rn3, fa3, drop3, rep3}), 64'd0);
    chk("reset5", 64'({wg5, wid5, rg5, rid5, rn5, fa5, drop5, rep5}), 64'd0);
    rst3_n = 1'b1;
    rst5_n = 1'b1;
    tick;

    for (int i = 0; i < 32; i++) begin
      {wq3, wd3, wa3, rq3, rdn3} = vecs[i].in;
      tick;
      chk($sformatf("vec%0d", i),
          64'({wg3, wid3, rg3, rid3, rn3, fa3, drop3, rep3}), vecs[i].exp);
    end
    {wq3, wd3, wa3, rq3, rdn3} = 5'b00000;

    // Drop counter saturation: reader pins buffer 0, every write past the fourth drops
    w5(1'b0);
    r5_get(last_rn);
    chk("sat_first_rd_new", 64'(last_rn), 64'd1);
    repeat (4) w5(1'b0);
    chk("sat_no_drop_yet", 64'(drop5), 64'd0);
    repeat (14) w5(1'b0);
    chk("sat_drop_14", 64'(drop5), 64'd14);
    repeat (6) w5(1'b0);
    chk("sat_drop_15", 64'(drop5), 64'd15);

    // Repeat counter saturation: one fresh read, then repeats only
    r5_done;
    r5_get(last_rn);
    chk("rep_fresh_rd_new", 64'(last_rn), 64'd1);
    chk("rep_zero", 64'(rep5), 64'd0);
    for (int i = 0; i < 14; i++) begin
      r5_done;
      r5_get(last_rn);
    end
    chk("rep_last_rd_new", 64'(last_rn), 64'd0);
    chk("rep_14", 64'(rep5), 64'd14);
    repeat (3) begin
      r5_done;
      r5_get(last_rn);
    end
    chk("rep_15", 64'(rep5), 64'd15);
    r5_done;

    // Random soak on 5 buffers
    w_pend = 1'b0; w_own = 1'b0; r_pend = 1'b0; r_own = 1'b0;
    w_age = 0; r_age = 0;
    for (int c = 0; c < 3000; c++) begin
      wd5 = 1'b0; wa5 = 1'b0; rdn5 = 1'b0;
      if (w_own) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 4) == 0) wa5 = 1'b1;
          else wd5 = 1'b1;
          w_own = 1'b0;
        end
      end else if (!w_pend && $urandom_range(0, 2) == 0) begin
        wq5 = 1'b1; w_pend = 1'b1; w_age = 0;
      end
      if (r_own) begin
        if ($urandom_range(0, 2) == 0) begin
          rdn5 = 1'b1; r_own = 1'b0;
        end
      end else if (!r_pend && $urandom_range(0, 2) == 0) begin
        rq5 = 1'b1; r_pend = 1'b1; r_age = 0;
      end
      tick;
      if (w_pend) w_age++;
      exp_wg = w_pend && (w_age == 2);
      chk("soak_wr_grant", 64'(wg5), 64'(exp_wg));
      if (exp_wg) begin
        w_pend = 1'b0; w_own = 1'b1; wq5 = 1'b0;
      end
      rpb = r_pend;
      chk("soak_rd_spurious", 64'(rg5 && !rpb), 64'd0);
      if (r_pend) begin
        r_age++;
        if (rg5) begin
          chk("soak_rd_avail", 64'(fa5), 64'd1);
          r_pend = 1'b0; r_own = 1'b1; rq5 = 1'b0;
        end else if (r_age > 400) begin
          chk("soak_rd_timeout", 64'(rg5), 64'd1);
          r_pend = 1'b0; rq5 = 1'b0;
        end
      end
      if (w_own && r_own) chk("soak_ids_distinct", 64'(wid5 != rid5), 64'd1);
    end

    // Mid-frame asynchronous reset: outputs clear without waiting for an edge
    {wq5, wd5, wa5, rq5, rdn5} = 5'b00000;
    #2;
    rst5_n = 1'b0;
    #1;
    chk("midreset_async", 64'({wg5, wid5, rg5, rid5, rn5, fa5, drop5, rep5}), 64'd0);
    @(posedge clk);
    #1;
    rst5_n = 1'b1;
    repeat (3) tick;
    chk("midreset_quiet", 64'({wg5, wid5, rg5, rid5, rn5, fa5, drop5, rep5}), 64'd0);
    wq5 = 1'b1;
    tick;
    tick;
    chk("midreset_regrant", 64'({wg5, wid5}), 64'({1'b1, 3'd0}));
    wq5 = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
